// File: rtl/trng_uart_tx_if.sv
// Sample/serial bundle between the TRNG sampler-UART and its environment.
// The master side drives the enable and random word; the slave side reports line and FIFO status.
interface trng_uart_tx_if #(
  parameter int unsigned FIFO_AW = 4
) ();
  logic               en;
  logic [7:0]         rnddata;
  logic               uart_txd;
  logic               tx_busy;
  logic [FIFO_AW:0]   fifo_level;
  logic               ovf;

  modport master (
    output en,
    output rnddata,
    input  uart_txd,
    input  tx_busy,
    input  fifo_level,
    input  ovf
  );

  modport slave (
    input  en,
    input  rnddata,
    output uart_txd,
    output tx_busy,
    output fifo_level,
    output ovf
  );
endinterface

// File: rtl/trng_uart_tx.sv
// Samples the TRNG word at a fixed rate into a small FIFO and ships each byte as an 8N1 UART frame.
// Samples arriving while the FIFO is full are dropped and latch a sticky overflow flag.
module trng_uart_tx #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned FIFO_AW    = 4
) (
  input logic           clk,
  input logic           rst,
  trng_uart_tx_if.slave bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned SCW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned BCW   = $clog2(BAUD_DIV);

  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BAUD_LAST   = BCW'(BAUD_DIV - 1);
  localparam logic [LW-1:0]  LVL_FULL    = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Sampler
  logic [SCW-1:0] samp_cnt_q, samp_cnt_d;
  logic           strobe;

  // FIFO
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               full, empty, push, pop;

  // Transmitter
  state_e         state_q, state_d;
  logic [BCW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           baud_last;

  always_comb begin
    strobe     = bus.en && (samp_cnt_q == SAMPLE_LAST);
    samp_cnt_d = samp_cnt_q + SCW'(1);
    if (!bus.en || strobe) begin
      samp_cnt_d = '0;
    end
  end

  // Fullness is judged on the registered level, so a same-cycle pop never rescues a push.
  always_comb begin
    full     = (level_q == LVL_FULL);
    empty    = (level_q == '0);
    push     = strobe && !full;
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q || (strobe && full);
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    baud_last = (baud_q == BAUD_LAST);
    if (state_q != ST_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + BCW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered: derive it from where the FSM will be next cycle.
    unique case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rnddata;
    end
  end

  assign bus.uart_txd   = txd_q;
  assign bus.tx_busy    = busy_q;
  assign bus.fifo_level = level_q;
  assign bus.ovf        = ovf_q;

endmodule
